// File: rtl/flp_normalize_pack.sv
// Normalise, round-to-nearest-even and pack an unnormalised sign/magnitude/exponent
// triple into an IEEE-754 single word through a three-stage stallable pipeline.
module flp_normalize_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [24:0] in_mag,
    input  logic [9:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_uf
);

    logic        adv;
    logic        v1_q, v2_q, v3_q;

    logic        s1_sign_q;
    logic [24:0] s1_mag_q;
    logic [9:0]  s1_exp_q;
    logic [4:0]  lz;
    logic        z;
    logic [23:0] sh;
    logic [10:0] e_d;

    logic        s2_sign_q;
    logic        s2_z_q;
    logic [23:0] s2_sh_q;
    logic [10:0] s2_e_q;

    logic        rnd_up;
    logic        carry;
    logic [22:0] frac_rnd;
    logic [10:0] e_rnd;
    logic [31:0] data_d, data_q;
    logic        zero_d, zero_q;
    logic        ovf_d, ovf_q;
    logic        uf_d, uf_q;

    assign adv       = ~v3_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = v3_q;
    assign out_data  = data_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_uf    = uf_q;

    // Highest set bit wins; an all-zero magnitude is carried by z instead.
    always_comb begin
        lz = 5'd24;
        for (int i = 0; i < 25; i++) begin
            if (s1_mag_q[i]) lz = 5'(24 - i);
        end
        z = (s1_mag_q == 25'd0);
    end

    // The hidden one (bit 24 after the shift) is implied and not carried on.
    assign sh  = 24'(s1_mag_q << lz);
    assign e_d = 11'd151 - {6'd0, lz} + {s1_exp_q[9], s1_exp_q};

    always_comb begin
        rnd_up   = s2_sh_q[0] & s2_sh_q[1];
        carry    = rnd_up & (&s2_sh_q[23:1]);
        frac_rnd = s2_sh_q[23:1] + {22'd0, rnd_up};
        e_rnd    = s2_e_q + {10'd0, carry};
        data_d   = {s2_sign_q, e_rnd[7:0], frac_rnd};
        zero_d   = 1'b0;
        ovf_d    = 1'b0;
        uf_d     = 1'b0;
        if (s2_z_q) begin
            data_d = {s2_sign_q, 31'd0};
            zero_d = 1'b1;
        end else if ($signed(e_rnd) >= 11'sd255) begin
            data_d = {s2_sign_q, 8'hFF, 23'd0};
            ovf_d  = 1'b1;
        end else if ($signed(e_rnd) <= 11'sd0) begin
            data_d = {s2_sign_q, 31'd0};
            uf_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q  <= 25'd0;
            s1_exp_q  <= 10'd0;
            s2_sign_q <= 1'b0;
            s2_z_q    <= 1'b0;
            s2_sh_q   <= 24'd0;
            s2_e_q    <= 11'd0;
            data_q    <= 32'd0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            uf_q      <= 1'b0;
        end else if (adv) begin
            v1_q      <= in_valid;
            s1_sign_q <= in_sign;
            s1_mag_q  <= in_mag;
            s1_exp_q  <= in_exp;
            v2_q      <= v1_q;
            s2_sign_q <= s1_sign_q;
            s2_z_q    <= z;
            s2_sh_q   <= sh;
            s2_e_q    <= e_d;
            v3_q      <= v2_q;
            data_q    <= data_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            uf_q      <= uf_d;
        end
    end

endmodule

// File: tb/tb_flp_normalize_pack.sv
// Bench for flp_normalize_pack: directed corner cases, backpressure, reset
// flush and a randomized stream against an arithmetic reference model.
module tb_flp_normalize_pack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [24:0] in_mag;
    logic [9:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic        out_ovf;
    logic        out_uf;

    int errs = 0;
    int checks = 0;
    int pushed = 0;
    int popped = 0;
    logic [34:0] exp_q[$];

    flp_normalize_pack dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mag(in_mag), .in_exp(in_exp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero),
        .out_ovf(out_ovf), .out_uf(out_uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [34:0] got,
                       input logic [34:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Returns {zero, ovf, uf, word}; value = (-1)^s * mag * 2^ex.
    function automatic logic [34:0] ref_model(bit s, int mag, int ex);
        int p, t, be;
        longint sig, keep;
        logic [7:0] eb;
        logic [22:0] fr;
        if (mag == 0) return {3'b100, s, 31'd0};
        p = 0;
        t = mag;
        while (t > 1) begin
            t = t / 2;
            p++;
        end
        sig = longint'(mag) * (longint'(1) << (24 - p));
        keep = sig / 2;
        if ((sig % 2) == 1 && (keep % 2) == 1) keep = keep + 1;
        be = p + ex + 127;
        if (keep == (longint'(1) << 24)) begin
            keep = keep / 2;
            be = be + 1;
        end
        if (be >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (be <= 0) return {3'b001, s, 31'd0};
        eb = 8'(be);
        fr = 23'(keep);
        return {3'b000, s, eb, fr};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_pending", {34'd0, exp_q.size() != 0}, 35'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_result", {out_zero, out_ovf, out_uf, out_data},
                        exp_q.pop_front());
                    popped++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_sign, int'(in_mag),
                                          int'($signed(in_exp))));
                pushed++;
            end
        end
    end

    task automatic directed(input string tag, input bit s,
                            input logic [24:0] m, input int e,
                            input logic [34:0] want);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sign   = s;
        in_mag    = m;
        in_exp    = 10'(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {34'd0, out_valid}, 35'd0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, {34'd0, out_valid}, 35'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, {34'd0, out_valid}, 35'd1);
        chk(tag, {out_zero, out_ovf, out_uf, out_data}, want);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 35'(exp_q.size()), 35'd0);
    endtask

    logic [24:0] bp_mag[6];
    int          bp_exp[6];

    task automatic backpressure();
        int idx, stall, p0, c;
        bit seen;
        logic [34:0] first;
        for (int i = 0; i < 6; i++) begin
            bp_mag[i] = 25'h1000000 + 25'(i * 3 + 1);
            bp_exp[i] = i - 24;
        end
        first = ref_model(1'b0, int'(bp_mag[0]), bp_exp[0]);
        p0 = popped;
        idx = 0;
        stall = 0;
        seen = 1'b0;
        c = 0;
        while (idx < 6 && c < 40) begin
            @(posedge clk); #1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall = 4;
            end
            out_ready = (stall == 0);
            in_valid  = 1'b1;
            in_sign   = 1'b0;
            in_mag    = bp_mag[idx];
            in_exp    = 10'(bp_exp[idx]);
            @(negedge clk);
            if (stall > 0) begin
                chk("bp_in_ready", {34'd0, in_ready}, 35'd0);
                chk("bp_hold", {3'd0, out_data}, {3'd0, first[31:0]});
                stall--;
            end
            if (in_valid && in_ready) idx++;
            c++;
        end
        chk("bp_stalled", {34'd0, seen}, 35'd1);
        drain("bp_drain");
        chk("bp_count", 35'(popped - p0), 35'd6);
    endtask

    task automatic reset_flush();
        int c;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_mag   = 25'(i + 5);
            in_exp   = 10'd0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_valid", {34'd0, out_valid}, 35'd0);
        chk("rst_outs", {out_zero, out_ovf, out_uf, out_data}, 35'd0);
        chk("rst_ready", {34'd0, in_ready}, 35'd1);
        c = popped;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_none", 35'(popped - c), 35'd0);
        directed("post_rst", 1'b1, 25'd3, 0, {3'b000, 32'hC0400000});
    endtask

    task automatic random_stream();
        int p0, c, ex;
        p0 = pushed;
        c = 0;
        while (pushed - p0 < 1000 && c < 20000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sign   = 1'($urandom);
            case ($urandom_range(0, 4))
                0: in_mag = 25'($urandom);
                1: in_mag = 25'($urandom_range(0, 15));
                2: in_mag = 25'h1000000 | 25'($urandom);
                3: in_mag = 25'h1FFFFFF ^ 25'($urandom_range(0, 3));
                default: in_mag = 25'($urandom) >> $urandom_range(0, 24);
            endcase
            if ($urandom_range(0, 3) == 0) ex = $urandom_range(0, 1023) - 512;
            else ex = $urandom_range(0, 330) - 180;
            in_exp = 10'(ex);
            c++;
        end
        chk("rnd_accepted", 35'(pushed - p0), 35'd1000);
        drain("rnd_drain");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_mag    = 25'd0;
        in_exp    = 10'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("init_valid", {34'd0, out_valid}, 35'd0);
        chk("init_outs", {out_zero, out_ovf, out_uf, out_data}, 35'd0);
        chk("init_ready", {34'd0, in_ready}, 35'd1);

        directed("norm_top", 0, 25'h1000000, -24, {3'b000, 32'h3F800000});
        directed("norm_lz24", 0, 25'd1, 0, {3'b000, 32'h3F800000});
        directed("norm_neg3", 1, 25'd3, 0, {3'b000, 32'hC0400000});
        directed("rnd_tie", 0, 25'h1000001, -24, {3'b000, 32'h3F800000});
        directed("rnd_up", 0, 25'h1000003, -24, {3'b000, 32'h3F800002});
        directed("rnd_carry", 0, 25'h1FFFFFF, -24, {3'b000, 32'h40000000});
        directed("ovf_pos", 0, 25'd1, 128, {3'b010, 32'h7F800000});
        directed("ovf_neg", 1, 25'd1, 128, {3'b010, 32'hFF800000});
        directed("uf", 0, 25'd1, -127, {3'b001, 32'h00000000});
        directed("min_norm", 0, 25'd1, -126, {3'b000, 32'h00800000});
        directed("zero_neg", 1, 25'd0, 77, {3'b100, 32'h80000000});
        directed("zero_negexp", 1, 25'd0, -300, {3'b100, 32'h80000000});

        backpressure();
        reset_flush();
        random_stream();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
